// File: rtl/fp16_mul_pipe_if.sv
// Operand/result bundle for the FP16 multiplier pipeline.
//   A, B     : binary16 operands, driven by the master every cycle
//   Mul_Out  : binary16 product, driven by the multiplier (slave)
interface fp16_mul_pipe_if;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Mul_Out;

    modport master (output A, output B, input Mul_Out);
    modport slave  (input A, input B, output Mul_Out);
endinterface

// File: rtl/fp16_mul_pipe.sv
// Six-stage pipelined IEEE-754 binary16 multiplier, Mul_Out = A * B.
// Operands sampled on edge N produce a result on Mul_Out right after edge N+5.
// One operand pair per cycle, no stall. Subnormal inputs and outputs flush to zero.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears every stage
//   bus  : slave side of fp16_mul_pipe_if (A, B in; Mul_Out out)
module fp16_mul_pipe (
    input  logic           clk,
    input  logic           rst,
    fp16_mul_pipe_if.slave bus
);

    // S1: operand capture
    logic [15:0] a_q, a_d, b_q, b_d;

    // Class flags ride alongside the data: nan, zero, inf
    // S2: unpack / classify
    logic              s2_sign_q, s2_sign_d;
    logic signed [6:0] s2_exp_q, s2_exp_d;
    logic [10:0]       s2_ma_q, s2_ma_d, s2_mb_q, s2_mb_d;
    logic              s2_nan_q, s2_nan_d, s2_zero_q, s2_zero_d, s2_inf_q, s2_inf_d;

    // S3: mantissa product
    logic              s3_sign_q, s3_sign_d;
    logic signed [6:0] s3_exp_q, s3_exp_d;
    logic [21:0]       s3_prod_q, s3_prod_d;
    logic              s3_nan_q, s3_nan_d, s3_zero_q, s3_zero_d, s3_inf_q, s3_inf_d;

    // S4: normalized mantissa plus guard/round/sticky
    logic              s4_sign_q, s4_sign_d;
    logic signed [6:0] s4_exp_q, s4_exp_d;
    logic [10:0]       s4_mant_q, s4_mant_d;
    logic              s4_g_q, s4_g_d, s4_r_q, s4_r_d, s4_s_q, s4_s_d;
    logic              s4_nan_q, s4_nan_d, s4_zero_q, s4_zero_d, s4_inf_q, s4_inf_d;

    // S5: rounded fraction
    logic              s5_sign_q, s5_sign_d;
    logic signed [6:0] s5_exp_q, s5_exp_d;
    logic [9:0]        s5_frac_q, s5_frac_d;
    logic              s5_nan_q, s5_nan_d, s5_zero_q, s5_zero_d, s5_inf_q, s5_inf_d;

    // S6: packed result
    logic [15:0] out_q, out_d;

    // Stage-local combinational helpers
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] norm;
    logic        round_up;
    logic [11:0] rsum;

    always_comb begin
        // S1
        a_d = bus.A;
        b_d = bus.B;

        // S2: exponent field 0 (zero or subnormal) is treated as zero
        a_zero = (a_q[14:10] == 5'd0);
        b_zero = (b_q[14:10] == 5'd0);
        a_inf  = (a_q[14:10] == 5'd31) && (a_q[9:0] == 10'd0);
        b_inf  = (b_q[14:10] == 5'd31) && (b_q[9:0] == 10'd0);
        a_nan  = (a_q[14:10] == 5'd31) && (a_q[9:0] != 10'd0);
        b_nan  = (b_q[14:10] == 5'd31) && (b_q[9:0] != 10'd0);
        s2_sign_d = a_q[15] ^ b_q[15];
        s2_exp_d  = $signed({2'b00, a_q[14:10]}) + $signed({2'b00, b_q[14:10]}) - 7'sd15;
        s2_ma_d   = {1'b1, a_q[9:0]};
        s2_mb_d   = {1'b1, b_q[9:0]};
        s2_nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s2_zero_d = a_zero | b_zero;
        s2_inf_d  = a_inf | b_inf;

        // S3
        s3_sign_d = s2_sign_q;
        s3_exp_d  = s2_exp_q;
        s3_prod_d = s2_ma_q * s2_mb_q;
        s3_nan_d  = s2_nan_q;
        s3_zero_d = s2_zero_q;
        s3_inf_d  = s2_inf_q;

        // S4: product of two 1.x values lies in [1,4); align leading one to bit 21
        if (s3_prod_q[21]) begin
            norm     = s3_prod_q;
            s4_exp_d = s3_exp_q + 7'sd1;
        end else begin
            norm     = {s3_prod_q[20:0], 1'b0};
            s4_exp_d = s3_exp_q;
        end
        s4_sign_d = s3_sign_q;
        s4_mant_d = norm[21:11];
        s4_g_d    = norm[10];
        s4_r_d    = norm[9];
        s4_s_d    = |norm[8:0];
        s4_nan_d  = s3_nan_q;
        s4_zero_d = s3_zero_q;
        s4_inf_d  = s3_inf_q;

        // S5: round to nearest, ties to even
        round_up  = s4_g_q & (s4_r_q | s4_s_q | s4_mant_q[0]);
        rsum      = {1'b0, s4_mant_q} + {11'd0, round_up};
        s5_sign_d = s4_sign_q;
        if (rsum[11]) begin
            // 1.111..1 rounded up to 10.000..0
            s5_frac_d = rsum[10:1];
            s5_exp_d  = s4_exp_q + 7'sd1;
        end else begin
            s5_frac_d = rsum[9:0];
            s5_exp_d  = s4_exp_q;
        end
        s5_nan_d  = s4_nan_q;
        s5_zero_d = s4_zero_q;
        s5_inf_d  = s4_inf_q;

        // S6: specials in priority order NaN > zero > Inf > overflow > underflow
        if (s5_nan_q) begin
            out_d = 16'h7E00;
        end else if (s5_zero_q) begin
            out_d = 16'h0000;
        end else if (s5_inf_q || (s5_exp_q >= 7'sd31)) begin
            out_d = {s5_sign_q, 15'h7C00};
        end else if (s5_exp_q <= 7'sd0) begin
            out_d = 16'h0000;
        end else begin
            out_d = {s5_sign_q, s5_exp_q[4:0], s5_frac_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0; b_q <= '0;
            s2_sign_q <= 1'b0; s2_exp_q <= '0; s2_ma_q <= '0; s2_mb_q <= '0;
            s2_nan_q <= 1'b0; s2_zero_q <= 1'b0; s2_inf_q <= 1'b0;
            s3_sign_q <= 1'b0; s3_exp_q <= '0; s3_prod_q <= '0;
            s3_nan_q <= 1'b0; s3_zero_q <= 1'b0; s3_inf_q <= 1'b0;
            s4_sign_q <= 1'b0; s4_exp_q <= '0; s4_mant_q <= '0;
            s4_g_q <= 1'b0; s4_r_q <= 1'b0; s4_s_q <= 1'b0;
            s4_nan_q <= 1'b0; s4_zero_q <= 1'b0; s4_inf_q <= 1'b0;
            s5_sign_q <= 1'b0; s5_exp_q <= '0; s5_frac_q <= '0;
            s5_nan_q <= 1'b0; s5_zero_q <= 1'b0; s5_inf_q <= 1'b0;
            out_q <= '0;
        end else begin
            a_q <= a_d; b_q <= b_d;
            s2_sign_q <= s2_sign_d; s2_exp_q <= s2_exp_d; s2_ma_q <= s2_ma_d;
            s2_mb_q <= s2_mb_d;
            s2_nan_q <= s2_nan_d; s2_zero_q <= s2_zero_d; s2_inf_q <= s2_inf_d;
            s3_sign_q <= s3_sign_d; s3_exp_q <= s3_exp_d; s3_prod_q <= s3_prod_d;
            s3_nan_q <= s3_nan_d; s3_zero_q <= s3_zero_d; s3_inf_q <= s3_inf_d;
            s4_sign_q <= s4_sign_d; s4_exp_q <= s4_exp_d; s4_mant_q <= s4_mant_d;
            s4_g_q <= s4_g_d; s4_r_q <= s4_r_d; s4_s_q <= s4_s_d;
            s4_nan_q <= s4_nan_d; s4_zero_q <= s4_zero_d; s4_inf_q <= s4_inf_d;
            s5_sign_q <= s5_sign_d; s5_exp_q <= s5_exp_d; s5_frac_q <= s5_frac_d;
            s5_nan_q <= s5_nan_d; s5_zero_q <= s5_zero_d; s5_inf_q <= s5_inf_d;
            out_q <= out_d;
        end
    end

    assign bus.Mul_Out = out_q;

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// Self-checking bench for fp16_mul_pipe: directed literal cases, a burst, a mid-flight
// reset and a randomized run, all checked against an integer-arithmetic reference model.
module tb_fp16_mul_pipe;

    localparam int MaxCyc = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fp16_mul_pipe_if bus_if ();

    fp16_mul_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;   // number of rising edges seen
    logic [15:0] hist [MaxCyc];
    bit          vld  [MaxCyc];

    // Reference: exact integer product of the significands, rounded to 11 bits
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int     ea, eb, fa, fb, k, sh, e, biased;
        bit     sign, az, bz, ai, bi, an, bn;
        longint p, q, rem, half;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        sign = a[15] ^ b[15];
        az = (ea == 0);  bz = (eb == 0);
        ai = (ea == 31) && (fa == 0);  bi = (eb == 31) && (fb == 0);
        an = (ea == 31) && (fa != 0);  bn = (eb == 31) && (fb != 0);
        if (an || bn || (ai && bz) || (bi && az)) return 16'h7E00;
        if (az || bz) return 16'h0000;
        if (ai || bi) return {sign, 15'h7C00};
        p = longint'(1024 + fa) * longint'(1024 + fb);
        k = 0;
        while ((p >> (k + 1)) != 0) k++;
        sh   = k - 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        e = k + ea + eb - 50;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        biased = e + 15;
        if (biased >= 31) return {sign, 15'h7C00};
        if (biased <= 0) return 16'h0000;
        return {sign, 5'(biased), 10'(q)};
    endfunction

    // Record the expected result for every sampling edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                // Everything in flight (and the slot being sampled) drains out as zero
                for (int k = 0; k <= 5; k++) begin
                    if (cyc - k >= 0) begin
                        hist[cyc - k] = 16'h0000;
                        vld[cyc - k]  = 1'b1;
                    end
                end
            end else begin
                hist[cyc] = ref_mul(bus_if.A, bus_if.B);
                vld[cyc]  = 1'b1;
            end
            cyc = cyc + 1;
        end
    end

    // Compare every cycle once the output corresponds to a recorded sample
    initial begin
        int slot;
        forever begin
            @(negedge clk);
            slot = cyc - 1 - 5;
            if (slot >= 0 && vld[slot]) begin
                ntests++;
                if (bus_if.Mul_Out !== hist[slot]) begin
                    nfail++;
                    $display("FAIL model slot=%0d got=%h exp=%h", slot, bus_if.Mul_Out,
                             hist[slot]);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] got, input logic [15:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic single(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        check_lit($sformatf("model %h*%h", a, b), ref_mul(a, b), exp);
        @(negedge clk);
        bus_if.A = a;
        bus_if.B = b;
        @(negedge clk);
        bus_if.A = 16'h0000;
        bus_if.B = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        check_lit($sformatf("single %h*%h", a, b), bus_if.Mul_Out, exp);
    endtask

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        int unsigned r;
        v = 16'($urandom);
        r = $urandom_range(0, 9);
        if (r == 0) v[14:10] = 5'd0;
        else if (r == 1) begin
            v[14:10] = 5'd31;
            if ($urandom_range(0, 1) == 0) v[9:0] = 10'd0;
        end else if (r <= 4) v[14:10] = 5'($urandom_range(8, 22));
        return v;
    endfunction

    logic [15:0] st_a [13];
    logic [15:0] st_b [13];
    logic [15:0] st_e [13];
    logic [15:0] bu_a [5];
    logic [15:0] bu_b [5];
    logic [15:0] bu_e [5];

    initial begin
        st_a = '{16'h3C00, 16'h4000, 16'h3E00, 16'h4000, 16'h3800, 16'h3800, 16'hBC00,
                 16'hC000, 16'h0000, 16'hC400, 16'h7BFF, 16'h7C00, 16'h3C01};
        st_b = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4400, 16'h3800, 16'h4400, 16'h3C00,
                 16'hC200, 16'h4500, 16'h0000, 16'h7BFF, 16'h0000, 16'h3C01};
        st_e = '{16'h3C00, 16'h4400, 16'h3E00, 16'h4800, 16'h3400, 16'h4000, 16'hBC00,
                 16'h4600, 16'h0000, 16'h0000, 16'h7C00, 16'h7E00, 16'h3C02};
        bu_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800, 16'h3E00};
        bu_b = '{16'h3C00, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
        bu_e = '{16'h3C00, 16'h4400, 16'h4600, 16'h3C00, 16'h4200};

        bus_if.A = 16'h0000;
        bus_if.B = 16'h0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_lit("reset state", bus_if.Mul_Out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Extra model pins: inf sign, NaN input, underflow, overflow
        check_lit("model -inf*2", ref_mul(16'hFC00, 16'h4000), 16'hFC00);
        check_lit("model nan", ref_mul(16'h7E01, 16'h3C00), 16'h7E00);
        check_lit("model underflow", ref_mul(16'h0400, 16'h3800), 16'h0000);
        check_lit("model ovf neg", ref_mul(16'hF800, 16'h5000), 16'hFC00);

        for (int i = 0; i < 13; i++) single(st_a[i], st_b[i], st_e[i]);

        // Burst: back-to-back pairs, back-to-back results
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_if.A = bu_a[i];
            bus_if.B = bu_b[i];
        end
        @(negedge clk);
        bus_if.A = 16'h0000;
        bus_if.B = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_lit($sformatf("burst %0d", i), bus_if.Mul_Out, bu_e[i]);
        end

        // Reset with products in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.A = 16'h4000;
            bus_if.B = 16'h4200;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_lit("reset in flight", bus_if.Mul_Out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        bus_if.A = 16'h0000;
        bus_if.B = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_lit($sformatf("post reset %0d", i), bus_if.Mul_Out, 16'h0000);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus_if.A = rand_fp();
            bus_if.B = rand_fp();
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
